// File: rtl/dff_pkg.sv
// Shared defaults and the data type for the dff register environment.
package dff_pkg;

    localparam int unsigned DFF_WIDTH = 1;
    localparam int unsigned DFF_DEPTH = 1;

    typedef logic [DFF_WIDTH-1:0] data_t;

    localparam data_t DFF_RST_VAL = '0;

endpackage

// File: rtl/dff_stage.sv
// One register stage: WIDTH-bit data plus a valid flag, async active-low
// reset, synchronous clear and load enable.
module dff_stage
    import dff_pkg::*;
#(
    parameter int unsigned           WIDTH   = DFF_WIDTH,
    parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             v_i,
    output logic [WIDTH-1:0] q_o,
    output logic             v_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // Clear outranks enable, so a same-edge load is dropped.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (clr_i) begin
            data_d  = RST_VAL;
            valid_d = 1'b0;
        end else if (en_i) begin
            data_d  = d_i;
            valid_d = v_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= RST_VAL;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q_o = data_q;
    assign v_o = valid_q;

endmodule

// File: rtl/d_flip_flop.sv
// D-type register pipeline of DEPTH stages with enable, synchronous clear,
// complemented output and a valid flag that tracks data through the chain.
module d_flip_flop
    import dff_pkg::*;
#(
    parameter int unsigned      WIDTH   = DFF_WIDTH,
    parameter int unsigned      DEPTH   = DFF_DEPTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             q_valid
);

    logic [WIDTH-1:0] data_s  [DEPTH+1];
    logic             valid_s [DEPTH+1];

    // Every captured word enters the chain marked valid.
    assign data_s[0]  = d;
    assign valid_s[0] = 1'b1;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        dff_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk_i  (clk),
            .rst_ni (rst),
            .clr_i  (clr),
            .en_i   (en),
            .d_i    (data_s[gi]),
            .v_i    (valid_s[gi]),
            .q_o    (data_s[gi+1]),
            .v_o    (valid_s[gi+1])
        );
    end

    assign q       = data_s[DEPTH];
    assign qb      = ~data_s[DEPTH];
    assign q_valid = valid_s[DEPTH];

endmodule

// File: tb/tb_d_flip_flop.sv
// Directed bench for d_flip_flop: DEPTH=1 and DEPTH=3 instances share stimulus;
// a reference model pushes expectations that are popped after each edge.
module tb_d_flip_flop;

    logic       clk;
    logic       rst_n;
    logic [7:0] d;
    logic       en;
    logic       clr;

    logic [7:0] q1, qb1, q3, qb3;
    logic       v1, v3;

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned failed = 0;

    typedef struct {
        string      tag;
        logic [7:0] q1;
        logic       v1;
        logic [7:0] q3;
        logic       v3;
    } exp_t;

    exp_t sb[$];

    logic [7:0] m1_q;
    logic       m1_v;
    logic [7:0] m3_q [3];
    logic       m3_v [3];

    d_flip_flop #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'h00)) u_dut1 (
        .clk(clk), .rst(rst_n), .d(d), .en(en), .clr(clr),
        .q(q1), .qb(qb1), .q_valid(v1)
    );

    d_flip_flop #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'h00)) u_dut3 (
        .clk(clk), .rst(rst_n), .d(d), .en(en), .clr(clr),
        .q(q3), .qb(qb3), .q_valid(v3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m1_q = 8'h00;
        m1_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m3_q[i] = 8'h00;
            m3_v[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (!rst_n || clr) begin
            model_reset();
        end else if (en) begin
            m1_q = d;
            m1_v = 1'b1;
            for (int i = 2; i > 0; i--) begin
                m3_q[i] = m3_q[i-1];
                m3_v[i] = m3_v[i-1];
            end
            m3_q[0] = d;
            m3_v[0] = 1'b1;
        end
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag = tag;
        e.q1  = m1_q;
        e.v1  = m1_v;
        e.q3  = m3_q[2];
        e.v3  = m3_v[2];
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            failed++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".q1"},  q1,        e.q1);
            chk({e.tag, ".qb1"}, qb1,       ~e.q1);
            chk({e.tag, ".v1"},  {7'd0, v1}, {7'd0, e.v1});
            chk({e.tag, ".q3"},  q3,        e.q3);
            chk({e.tag, ".qb3"}, qb3,       ~e.q3);
            chk({e.tag, ".v3"},  {7'd0, v3}, {7'd0, e.v3});
        end
    endtask

    // Inputs are stable here; the model sees what the DUT samples at the edge.
    task automatic step(input string tag);
        model_edge();
        push_exp(tag);
        @(posedge clk);
        #1;
        compare();
    endtask

    initial begin
        rst_n = 1'b0;
        d     = 8'hFF;
        en    = 1'b1;
        clr   = 1'b0;
        model_reset();
        push_exp("reset_t0");
        #1;
        compare();

        for (int i = 0; i < 10; i++) step("reset_hold");
        chk("reset_q_lit",  q1,  8'h00);
        chk("reset_qb_lit", qb1, 8'hFF);

        rst_n = 1'b1;
        d     = 8'hA5;
        en    = 1'b1;
        step("capture");
        chk("capture_q_lit",  q1,  8'hA5);
        chk("capture_qb_lit", qb1, 8'h5A);
        chk("capture_v_lit",  {7'd0, v1}, 8'h01);

        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = (i % 2 == 0) ? 8'h00 : 8'hFF;
            step("hold");
        end
        chk("hold_q_lit", q1, 8'hA5);

        clr = 1'b1;
        en  = 1'b1;
        d   = 8'h3C;
        step("clear");
        chk("clear_q_lit", q1, 8'h00);
        chk("clear_v_lit", {7'd0, v1}, 8'h00);
        clr = 1'b0;

        for (int i = 1; i <= 6; i++) begin
            d = 8'(i);
            step("stream");
            if (i >= 3) chk("stream_q3_lit", q3, 8'(i - 2));
            if (i == 2) chk("stream_v3_low", {7'd0, v3}, 8'h00);
            if (i == 3) chk("stream_v3_rise", {7'd0, v3}, 8'h01);
        end

        // Pipeline is full; drop reset mid-cycle and check before the next edge.
        d = 8'h07;
        #3;
        rst_n = 1'b0;
        model_reset();
        push_exp("async_rst");
        #1;
        compare();
        chk("async_q3_lit", q3, 8'h00);
        chk("async_v3_lit", {7'd0, v3}, 8'h00);

        step("async_held");
        step("async_held");

        rst_n = 1'b1;
        d = 8'h09;
        step("refill");
        d = 8'h0A;
        step("refill");
        chk("refill_v3_low", {7'd0, v3}, 8'h00);
        d = 8'h0B;
        step("refill");
        chk("refill_v3_rise", {7'd0, v3}, 8'h01);
        chk("refill_q3_lit",  q3, 8'h09);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/d_flip_flop.md
# d_flip_flop

Parameterizable D-type register stage with enable, synchronous clear and optional pipeline depth. It is the leaf storage element of the `dff` verification environment. The RTL sits behind the `dff_if` interface, which carries the clock and reset from the top level. A separately bound assertion module observes it.

## Interface
Parameters:
- `WIDTH`, 1: data width in bits (≥1).
- `DEPTH`, 1: number of register stages between `d` and `q` (≥1).
- `RST_VAL`, '0: value loaded into every stage on reset; WIDTH bits.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `d`  in  WIDTH  data input.
- `en`  in  1  load enable; stages advance only when high.
- `clr`  in  1  synchronous clear; loads RST_VAL into all stages.
- `q`  out  WIDTH  registered output (last stage).
- `qb`  out  WIDTH  bitwise complement of `q`.
- `q_valid`  out  1  high once `q` holds data captured from `d` since reset/clear.

## Operation
- Reset (`rst`=0, asynchronous):
  - All stages = RST_VAL, `q`=RST_VAL, `qb`=~RST_VAL, `q_valid`=0, immediately, without waiting for a clock edge.
  - Held while `rst` is low.
- Priority per rising edge: reset > `clr` > `en` > hold.
- `clr`=1:
  - All stages = RST_VAL and `q_valid`=0, regardless of `en`.
- `en`=1, `clr`=0:
  - stage[0] ← `d`; stage[i] ← stage[i-1]; `q` = stage[DEPTH-1].
  - Valid bit pipeline shifts in 1 alongside the data.
  - `q_valid` = valid bit of the last stage.
- `en`=0, `clr`=0: all stages and valid bits hold.
- `qb` is combinational `~q`, never X when `q` is known.
- No X propagation from `en`/`clr` is required; both are assumed known after reset release.

## Timing
- Latency `d`→`q` = DEPTH enabled rising edges; with DEPTH=1, `q` updates on the first edge with `en`=1.
- `q_valid` rises on the DEPTH-th enabled edge after reset release or clear.
- Reset release:
  - The first edge at which `rst` is sampled high may capture data.
  - Release must meet recovery timing relative to `clk`; the bench releases away from the rising edge.
- Reset asserted mid-operation discards all in-flight data the same instant.
- `clr` and `en` high on the same edge: clear wins, `d` is dropped.
- `d` is sampled only at the rising edge; glitches between edges have no effect.

## Structure
- Package `dff_pkg`: default WIDTH/DEPTH/RST_VAL constants and the `data_t` typedef (`logic [WIDTH-1:0]`), shared with `dff_if`, the testbench and the assertions.
- Sub-module `dff_stage`:
  - one WIDTH-bit register plus valid bit, with async reset, clear and enable;
  - instantiated DEPTH times by a generate loop in `d_flip_flop`.
- `dff_if`:
  - bundles `clk`, `rst`, `d`, `en`, `clr`, `q`, `qb`, `q_valid`;
  - modports for the DUT, the driver and the monitor;
  - clocking block sampling on the rising edge of `clk`.
- Assertions are bound externally and are not part of the RTL.

## Test plan
- Reset:
  - hold `rst`=0 for 10 cycles, driving `d`=8'hFF, `en`=1;
  - required: `q`=RST_VAL(8'h00), `qb`=8'hFF, `q_valid`=0 throughout.
- Basic capture (WIDTH=8, DEPTH=1):
  - after reset release, drive `d`=8'hA5, `en`=1 for one edge;
  - required: `q`=8'hA5, `qb`=8'h5A, `q_valid`=1 after that edge.
- Hold:
  - `en`=0, `d` toggles 8'h00/8'hFF for 5 cycles;
  - required: `q` stays 8'hA5.
- Clear priority:
  - `clr`=1, `en`=1, `d`=8'h3C on one edge;
  - required: `q`=8'h00, `q_valid`=0, and 8'h3C is never observed.
- Pipeline (DEPTH=3):
  - stream 1, 2, 3, 4 with `en`=1 continuously;
  - required: `q`=1 on the 3rd edge, then 2, 3, 4 on successive edges;
  - `q_valid` rises on the 3rd edge.
- Async reset mid-stream:
  - drop `rst` between edges while the DEPTH=3 pipeline is full;
  - required: `q`=RST_VAL and `q_valid`=0 before the next rising edge;
  - after release, 3 more enabled edges are needed before `q_valid`=1.
